// File: rtl/serv_bus_arbiter_pkg.sv
// rtl/serv_bus_arbiter_pkg.sv - shared encodings and tie-break helper for the bus arbiter
package serv_bus_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_GNT_I = 2'd1;
   localparam logic [1:0] ARB_GNT_D = 2'd2;
   localparam logic [1:0] ARB_TURN  = 2'd3;

   localparam int ARB_PRIO_RR   = 0;
   localparam int ARB_PRIO_DBUS = 1;

   // last_d is high when the previous grant went to dbus
   function automatic logic pick_dbus(input logic ibus_cyc, input logic dbus_cyc,
                                      input logic last_d, input logic dbus_prio);
      return dbus_cyc & (~ibus_cyc | dbus_prio | ~last_d);
   endfunction

endpackage

// File: rtl/serv_arb_wdog.sv
// rtl/serv_arb_wdog.sv - grant watchdog counter, expires on the TIMEOUT-th stalled cycle
module serv_arb_wdog
   import serv_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT   = 0,
   parameter int TIMEOUT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic                 ENABLED = (TIMEOUT != 0);

   logic [TIMEOUT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && cnt != LAST)
         cnt <= cnt + 1'b1;
   end

   assign expire = ENABLED & (cnt == LAST);

endmodule

// File: rtl/serv_bus_arbiter.sv
// rtl/serv_bus_arbiter.sv - merges ibus and dbus onto one registered Wishbone classic master
module serv_bus_arbiter
   import serv_bus_arbiter_pkg::*;
#(
   parameter int PRIORITY  = 0,
   parameter int TIMEOUT   = 0,
   parameter int TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic [31:0] o_ibus_rdt,
   output logic        o_ibus_ack,
   input  logic [31:0] i_dbus_adr,
   input  logic [31:0] i_dbus_dat,
   input  logic [3:0]  i_dbus_sel,
   input  logic        i_dbus_we,
   input  logic        i_dbus_cyc,
   output logic [31:0] o_dbus_rdt,
   output logic        o_dbus_ack,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack,
   output logic        o_timeout,
   output logic        o_busy
);

   localparam logic DBUS_PRIO = (PRIORITY == ARB_PRIO_DBUS);

   logic [1:0]  state;
   logic        last_d;
   logic        pick_d;
   logic        grant_i;
   logic        grant_d;
   logic        gnt_i;
   logic        gnt_d;
   logic        in_gnt;
   logic        owner_cyc;
   logic        expire;
   logic        fake_ack;
   logic        ack;
   logic [31:0] rdt;

   always_comb begin
      pick_d    = pick_dbus(i_ibus_cyc, i_dbus_cyc, last_d, DBUS_PRIO);
      grant_d   = (state == ARB_IDLE) & pick_d;
      grant_i   = (state == ARB_IDLE) & i_ibus_cyc & ~pick_d;
      gnt_i     = (state == ARB_GNT_I);
      gnt_d     = (state == ARB_GNT_D);
      in_gnt    = gnt_i | gnt_d;
      owner_cyc = gnt_i ? i_ibus_cyc : i_dbus_cyc;
      // An abandoned request never receives a watchdog ack
      fake_ack  = in_gnt & expire & ~i_wb_ack & owner_cyc;
      ack       = in_gnt & (i_wb_ack | fake_ack);
      rdt       = fake_ack ? 32'h0 : i_wb_rdt;
   end

   assign o_ibus_ack = gnt_i & ack;
   assign o_dbus_ack = gnt_d & ack;
   assign o_ibus_rdt = gnt_i ? rdt : 32'h0;
   assign o_dbus_rdt = gnt_d ? rdt : 32'h0;
   assign o_timeout  = fake_ack;
   assign o_busy     = (state != ARB_IDLE);

   serv_arb_wdog #(
      .TIMEOUT   (TIMEOUT),
      .TIMEOUT_W (TIMEOUT_W)
   ) u_wdog (
      .clk    (clk),
      .rst    (i_rst),
      .clr    (grant_i | grant_d),
      .en     (in_gnt & ~i_wb_ack),
      .expire (expire)
   );

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= ARB_IDLE;
         last_d   <= 1'b0;
         o_wb_adr <= 32'h0;
         o_wb_dat <= 32'h0;
         o_wb_sel <= 4'h0;
         o_wb_we  <= 1'b0;
         o_wb_cyc <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grant_d) begin
                  state    <= ARB_GNT_D;
                  last_d   <= 1'b1;
                  o_wb_adr <= i_dbus_adr;
                  o_wb_dat <= i_dbus_dat;
                  o_wb_sel <= i_dbus_sel;
                  o_wb_we  <= i_dbus_we;
                  o_wb_cyc <= 1'b1;
               end else if (grant_i) begin
                  state    <= ARB_GNT_I;
                  last_d   <= 1'b0;
                  o_wb_adr <= i_ibus_adr;
                  o_wb_dat <= 32'h0;
                  o_wb_sel <= 4'hF;
                  o_wb_we  <= 1'b0;
                  o_wb_cyc <= 1'b1;
               end
            end
            ARB_GNT_I, ARB_GNT_D: begin
               if (i_wb_ack || fake_ack || !owner_cyc) begin
                  state    <= ARB_TURN;
                  o_wb_cyc <= 1'b0;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
